// File: rtl/serv_pwr_pkg.sv
// Shared definitions for the SERV power controller.
//   pwr_state_t : power FSM state, 2-bit encoding RUN=0, DRAIN=1, SLEEP=2, WAKE=3
//   WAKE_CNT_W  : width of the wake settling counter
package serv_pwr_pkg;

  localparam int WAKE_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } pwr_state_t;

endpackage

// File: rtl/serv_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear, count -> 0 (wins over inc)
//   inc   : increment by one, holding at all-ones
//   count : current value
module serv_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // One extra bit catches the carry out of the all-ones value, which
  // tells us to hold instead of wrapping.
  logic [W:0] sum;
  assign sum = {1'b0, count} + (W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !sum[W]) begin
      count <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/serv_pwr_ctrl.sv
// Sleep/wake power controller between the SERV core and the clock gate.
// The core asks to sleep (WFI retired); outstanding bus activity is drained,
// the core clock enable is dropped, and the core is held asleep until a
// wake source appears. A programmable settling delay runs before the clock
// enable comes back.
//
// Request signalling: i_sleep_req and i_wakeup_req are levels, sampled on
// every rising edge with no acknowledge; a request only has effect in the
// states that listen for it, and a pending wakeup always beats a sleep.
//
// Ports:
//   i_clk          : core clock
//   i_rst          : synchronous active-high reset
//   i_sleep_req    : core requests sleep
//   i_wakeup_req   : wake source pending
//   i_bus_idle     : no outstanding ibus/dbus transaction
//   i_cnt_clr      : clear the sleep-cycle counter
//   o_core_en      : core clock enable (registered)
//   o_sleeping     : high while in SLEEP (registered)
//   o_wake_pulse   : one cycle high on the first RUN cycle after a wake
//   o_sleep_cycles : saturating count of cycles spent in SLEEP
//   o_state        : current FSM state, for debug and checkers
module serv_pwr_ctrl
  import serv_pwr_pkg::*;
#(
  parameter int WAKE_DELAY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sleep_req,
  input  logic             i_wakeup_req,
  input  logic             i_bus_idle,
  input  logic             i_cnt_clr,
  output logic             o_core_en,
  output logic             o_sleeping,
  output logic             o_wake_pulse,
  output logic [CNT_W-1:0] o_sleep_cycles,
  output pwr_state_t       o_state
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_DELAY);

  pwr_state_t            state, state_n;
  logic [WAKE_CNT_W-1:0] wake_cnt, wake_cnt_n;
  logic                  core_en_n;
  logic                  sleeping_n;
  logic                  wake_pulse_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= RUN;
      wake_cnt     <= '0;
      o_core_en    <= 1'b1;
      o_sleeping   <= 1'b0;
      o_wake_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      wake_cnt     <= wake_cnt_n;
      o_core_en    <= core_en_n;
      o_sleeping   <= sleeping_n;
      o_wake_pulse <= wake_pulse_n;
    end
  end

  always_comb begin
    state_n      = state;
    wake_cnt_n   = wake_cnt;
    core_en_n    = o_core_en;
    sleeping_n   = o_sleeping;
    wake_pulse_n = 1'b0;

    case (state)
      RUN: begin
        core_en_n  = 1'b1;
        sleeping_n = 1'b0;
        // During the wake-pulse cycle the core has not yet retired its WFI,
        // so a still-high sleep request is stale and must not re-enter.
        if (i_sleep_req && !i_wakeup_req && !o_wake_pulse) begin
          state_n   = DRAIN;
          core_en_n = 1'b0;
        end
      end
      DRAIN: begin
        core_en_n = 1'b0;
        if (i_wakeup_req) begin
          state_n    = WAKE;
          wake_cnt_n = WAKE_LOAD;
        end else if (i_bus_idle) begin
          state_n    = SLEEP;
          sleeping_n = 1'b1;
        end
      end
      SLEEP: begin
        core_en_n  = 1'b0;
        sleeping_n = 1'b1;
        if (i_wakeup_req) begin
          state_n    = WAKE;
          wake_cnt_n = WAKE_LOAD;
          sleeping_n = 1'b0;
        end
      end
      WAKE: begin
        core_en_n  = 1'b0;
        sleeping_n = 1'b0;
        // Committed once entered: the wake source dropping does not abort.
        if (wake_cnt == '0) begin
          state_n      = RUN;
          core_en_n    = 1'b1;
          wake_pulse_n = 1'b1;
        end else begin
          wake_cnt_n = wake_cnt - WAKE_CNT_W'(1);
        end
      end
      default: begin
        state_n   = RUN;
        core_en_n = 1'b1;
      end
    endcase
  end

  serv_sat_counter #(
    .W (CNT_W)
  ) u_sleep_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (i_cnt_clr),
    .inc   (state == SLEEP),
    .count (o_sleep_cycles)
  );

  assign o_state = state;

endmodule

// File: tb/tb_serv_pwr_ctrl.sv
// Bench for serv_pwr_ctrl. Three instances share one stimulus stream:
//   dut0 : WAKE_DELAY=4, CNT_W=16
//   dut1 : WAKE_DELAY=4, CNT_W=4  (saturation)
//   dut2 : WAKE_DELAY=0, CNT_W=16 (zero delay)
// A behavioural model predicts every instance's outputs when stimulus is
// driven; predictions queue up and are compared after the following edge.
// Directed checks pin the specific cycle numbers of each scenario.
module tb_serv_pwr_ctrl;
  import serv_pwr_pkg::*;

  // ---------------- clock / reset / inputs ----------------
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_sleep_req = 1'b0;
  logic i_wakeup_req = 1'b0;
  logic i_bus_idle = 1'b1;
  logic i_cnt_clr = 1'b0;

  always #5 i_clk = ~i_clk;

  logic        en0, sl0, pl0, en1, sl1, pl1, en2, sl2, pl2;
  logic [15:0] cnt0, cnt2;
  logic [3:0]  cnt1;
  pwr_state_t  st0, st1, st2;

  serv_pwr_ctrl #(.WAKE_DELAY(4), .CNT_W(16)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_sleep_req(i_sleep_req),
    .i_wakeup_req(i_wakeup_req), .i_bus_idle(i_bus_idle), .i_cnt_clr(i_cnt_clr),
    .o_core_en(en0), .o_sleeping(sl0), .o_wake_pulse(pl0),
    .o_sleep_cycles(cnt0), .o_state(st0));

  serv_pwr_ctrl #(.WAKE_DELAY(4), .CNT_W(4)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_sleep_req(i_sleep_req),
    .i_wakeup_req(i_wakeup_req), .i_bus_idle(i_bus_idle), .i_cnt_clr(i_cnt_clr),
    .o_core_en(en1), .o_sleeping(sl1), .o_wake_pulse(pl1),
    .o_sleep_cycles(cnt1), .o_state(st1));

  serv_pwr_ctrl #(.WAKE_DELAY(0), .CNT_W(16)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_sleep_req(i_sleep_req),
    .i_wakeup_req(i_wakeup_req), .i_bus_idle(i_bus_idle), .i_cnt_clr(i_cnt_clr),
    .o_core_en(en2), .o_sleeping(sl2), .o_wake_pulse(pl2),
    .o_sleep_cycles(cnt2), .o_state(st2));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // packed expectation: {state[1:0], core_en, sleeping, wake_pulse, count[15:0]}
  logic [20:0] exp_q0[$];
  logic [20:0] exp_q1[$];
  logic [20:0] exp_q2[$];

  int m_st[3], m_wc[3], m_sc[3];
  bit m_en[3], m_sl[3], m_pl[3];
  int p_wd[3]  = '{4, 4, 0};
  int p_max[3] = '{65535, 15, 65535};

  task automatic model_step(input int k, input bit r, input bit s, input bit w,
                            input bit idle, input bit c);
    int st, wc, sc;
    bit en, sl, pl;
    logic [20:0] e;
    if (r) begin
      st = 0; wc = 0; sc = 0; en = 1'b1; sl = 1'b0; pl = 1'b0;
    end else begin
      st = m_st[k]; wc = m_wc[k]; sc = m_sc[k];
      en = m_en[k]; sl = m_sl[k]; pl = 1'b0;
      if (m_st[k] == 2 && sc < p_max[k]) sc = sc + 1;
      if (c) sc = 0;
      case (m_st[k])
        0: if (s && !w && !m_pl[k]) begin st = 1; en = 1'b0; end
        1: if (w) begin st = 3; wc = p_wd[k]; end
           else if (idle) begin st = 2; sl = 1'b1; end
        2: if (w) begin st = 3; wc = p_wd[k]; sl = 1'b0; end
        default: if (m_wc[k] == 0) begin st = 0; en = 1'b1; pl = 1'b1; end
                 else wc = m_wc[k] - 1;
      endcase
    end
    m_st[k] = st; m_wc[k] = wc; m_sc[k] = sc;
    m_en[k] = en; m_sl[k] = sl; m_pl[k] = pl;
    e = {2'(st), en, sl, pl, 16'(sc)};
    if (k == 0) exp_q0.push_back(e);
    else if (k == 1) exp_q1.push_back(e);
    else exp_q2.push_back(e);
  endtask

  // ---------------- driver ----------------
  // Drive inputs for the current cycle, predict, clock once, compare.
  task automatic cycle(input bit r, input bit s, input bit w, input bit idle, input bit c);
    i_rst = r; i_sleep_req = s; i_wakeup_req = w; i_bus_idle = idle; i_cnt_clr = c;
    for (int k = 0; k < 3; k++) model_step(k, r, s, w, idle, c);
    @(posedge i_clk);
    #1;
    cyc++;
    if (exp_q0.size() == 0) check("sb0_empty", 32'd0, 32'd1);
    else check("sb0", 32'({st0, en0, sl0, pl0, cnt0}), 32'(exp_q0.pop_front()));
    if (exp_q1.size() == 0) check("sb1_empty", 32'd0, 32'd1);
    else check("sb1", 32'({st1, en1, sl1, pl1, 12'd0, cnt1}), 32'(exp_q1.pop_front()));
    if (exp_q2.size() == 0) check("sb2_empty", 32'd0, 32'd1);
    else check("sb2", 32'({st2, en2, sl2, pl2, cnt2}), 32'(exp_q2.pop_front()));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_core_en", 32'(en0), 32'd1);
    check("rst_sleeping", 32'(sl0), 32'd0);
    check("rst_pulse", 32'(pl0), 32'd0);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_state", 32'(st0), 32'(RUN));
    cyc = 0;

    // Basic sleep/wake: sleep_req in cycle 10, wakeup_req in cycle 20
    while (cyc < 10) idle_cycles(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("basic_en_c11", 32'(en0), 32'd0);
    check("basic_st_c11", 32'(st0), 32'(DRAIN));
    idle_cycles(1);
    check("basic_slp_c12", 32'(sl0), 32'd1);
    while (cyc < 20) idle_cycles(1);
    check("basic_slp_c20", 32'(sl0), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("basic_slp_c21", 32'(sl0), 32'd0);
    check("basic_st_c21", 32'(st0), 32'(WAKE));
    idle_cycles(4);
    check("basic_en_c25", 32'(en0), 32'd0);
    idle_cycles(1);
    check("basic_en_c26", 32'(en0), 32'd1);
    check("basic_pulse_c26", 32'(pl0), 32'd1);
    check("basic_count", 32'(cnt0), 32'd9);
    idle_cycles(1);
    check("basic_pulse_c27", 32'(pl0), 32'd0);
    idle_cycles(2);

    // Simultaneous requests: wakeup wins, stay in RUN
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("simul_state", 32'(st0), 32'(RUN));
      check("simul_en", 32'(en0), 32'd1);
      check("simul_pulse", 32'(pl0), 32'd0);
    end
    idle_cycles(2);

    // Drain stall then abort via wakeup
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drain_state", 32'(st0), 32'(DRAIN));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("drain_hold", 32'(st0), 32'(DRAIN));
      check("drain_slp", 32'(sl0), 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_state", 32'(st0), 32'(WAKE));
    for (int i = 0; i < 4; i++) begin
      idle_cycles(1);
      check("abort_en_low", 32'(en0), 32'd0);
      check("abort_slp", 32'(sl0), 32'd0);
    end
    idle_cycles(1);
    check("abort_en_back", 32'(en0), 32'd1);
    check("abort_count", 32'(cnt0), 32'd9);
    idle_cycles(2);

    // Saturation and clear (dut1 is 4 bits wide)
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(21);
    check("sat_mid", 32'(cnt1), 32'd15);
    idle_cycles(20);
    check("sat_state", 32'(st1), 32'(SLEEP));
    check("sat_hold", 32'(cnt1), 32'd15);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_sat", 32'(cnt1), 32'd0);
    check("clr_wide", 32'(cnt0), 32'd0);
    idle_cycles(1);
    check("clr_recount", 32'(cnt1), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(7);

    // Zero delay with lingering sleep_req (dut2)
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("zd_sleep", 32'(st2), 32'(SLEEP));
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("zd_wake_state", 32'(st2), 32'(WAKE));
    check("zd_wake_en", 32'(en2), 32'd0);
    check("zd_wake_slp", 32'(sl2), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("zd_run_en", 32'(en2), 32'd1);
    check("zd_run_pulse", 32'(pl2), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("zd_no_reentry", 32'(st2), 32'(RUN));
    check("zd_en_hold", 32'(en2), 32'd1);
    check("zd_pulse_once", 32'(pl2), 32'd0);
    idle_cycles(8);

    // Reset in SLEEP
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(2);
    check("rs_pre_state", 32'(st0), 32'(SLEEP));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rs_sleep_en", 32'(en0), 32'd1);
    check("rs_sleep_slp", 32'(sl0), 32'd0);
    check("rs_sleep_pulse", 32'(pl0), 32'd0);
    check("rs_sleep_cnt", 32'(cnt0), 32'd0);
    // Reset in WAKE
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles(1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(1);
    check("rw_pre_state", 32'(st0), 32'(WAKE));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rw_state", 32'(st0), 32'(RUN));
    check("rw_en", 32'(en0), 32'd1);
    check("rw_slp", 32'(sl0), 32'd0);
    check("rw_pulse", 32'(pl0), 32'd0);
    check("rw_cnt", 32'(cnt0), 32'd0);
    idle_cycles(2);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 40) == 0));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
